pudding_dac_loader: RTL

- Parametrised successor to the single-pair DAC code register.
- Holds N_CH independent channels. Each channel has a CH_BITS serial daisychain (shadow) and a CH_BITS live state register that drives an unary current-DAC array.
- Adds per-channel addressing, a frame bit counter, optional auto-commit, and break-before-make enable blanking around every commit.
- Sits between the pad-level control inputs and the dac128module instances plus the enable inverter-pair drivers.

---
 rtl/pudding_pkg.sv | 16 +
 rtl/pudding_dac_loader_if.sv | 36 +++
 rtl/pudding_chan_reg.sv | 33 +++
 rtl/pudding_dac_loader.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pudding_pkg.sv
// Shared types and helpers for the multi-channel unary DAC code loader.
package pudding_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_RESTORE = 2'd3
  } pudding_state_t;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int sel_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/pudding_dac_loader_if.sv
// Pad-side control bundle and DAC-side outputs of the loader.
interface pudding_dac_loader_if
  import pudding_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int CH_BITS = 128,
  parameter int EN_BITS = 4
);
  localparam int SEL_W = sel_width(N_CH);

  // shift and xfer are single-cycle strobes sampled every clock; busy=1 means
  // the loader is not ready and any strobe seen in that cycle is dropped.
  logic                      sdi;
  logic                      shift;
  logic                      xfer;
  logic                      dir;
  logic [SEL_W-1:0]          ch_sel;
  logic                      auto_commit;
  logic [N_CH-1:0]           en_req;
  logic                      sdo;
  logic                      frame_done;
  logic                      busy;
  logic [N_CH*CH_BITS-1:0]   on_code;
  logic [N_CH*EN_BITS-1:0]   en_out;
  pudding_state_t            dbg_state;

  modport master (
    output sdi, shift, xfer, dir, ch_sel, auto_commit, en_req,
    input  sdo, frame_done, busy, on_code, en_out, dbg_state
  );

  modport slave (
    input  sdi, shift, xfer, dir, ch_sel, auto_commit, en_req,
    output sdo, frame_done, busy, on_code, en_out, dbg_state
  );
endinterface

// File: rtl/pudding_chan_reg.sv
// One channel: serial shadow chain plus the live state register it commits to.
module pudding_chan_reg #(
  parameter int CH_BITS = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_shift,
  input  logic               i_load_chain,
  input  logic               i_load_state,
  input  logic               i_sdi,
  output logic [CH_BITS-1:0] o_chain,
  output logic [CH_BITS-1:0] o_state
);
  logic [CH_BITS-1:0] r_chain;
  logic [CH_BITS-1:0] r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chain <= '0;
      r_state <= '0;
    end else begin
      if (i_load_chain)
        r_chain <= r_state;
      else if (i_shift)
        r_chain <= {r_chain[CH_BITS-2:0], i_sdi};
      if (i_load_state)
        r_state <= r_chain;
    end
  end

  assign o_chain = r_chain;
  assign o_state = r_state;
endmodule

// File: rtl/pudding_dac_loader.sv
// Multi-channel DAC code loader: addressed shifting, frame counting and a
// break-before-make commit sequence that blanks the channel enables.
module pudding_dac_loader
  import pudding_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int CH_BITS   = 128,
  parameter int EN_BITS   = 4,
  parameter int BLANK_CYC = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  pudding_dac_loader_if.slave bus
);
  localparam int SEL_W = sel_width(N_CH);
  localparam int CNT_W = $clog2(CH_BITS + 1);
  localparam int BC_W  = $clog2(BLANK_CYC + 1);
  localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

  pudding_state_t          r_state, w_state_next;
  logic [SEL_W-1:0]        r_prev_sel;
  logic [SEL_W-1:0]        r_lat_ch, w_lat_ch_next;
  logic [CNT_W-1:0]        r_cnt, w_cnt_next;
  logic [BC_W-1:0]         r_blank_cnt, w_blank_next;
  logic [N_CH*EN_BITS-1:0] r_en, w_en_next;
  logic [N_CH-1:0]         w_shift_en, w_load_chain, w_load_state;
  logic [CH_BITS-1:0]      w_chain [N_CH];
  logic [CH_BITS-1:0]      w_state [N_CH];
  logic                    w_sel_valid, w_sel_chg, w_blanking;

  assign w_sel_valid = ({1'b0, bus.ch_sel} < N_CH_L);
  assign w_sel_chg   = (bus.ch_sel != r_prev_sel);
  assign w_blanking  = (r_state == ST_BLANK) || (r_state == ST_COMMIT);

  always_comb begin
    w_state_next  = r_state;
    w_lat_ch_next = r_lat_ch;
    w_cnt_next    = r_cnt;
    w_blank_next  = r_blank_cnt;
    w_shift_en    = '0;
    w_load_chain  = '0;
    w_load_state  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_chg)
          w_cnt_next = '0;
        if (bus.xfer && w_sel_valid) begin
          w_cnt_next = '0;
          if (bus.dir) begin
            w_state_next  = ST_BLANK;
            w_lat_ch_next = bus.ch_sel;
            w_blank_next  = BC_W'(BLANK_CYC - 1);
          end else begin
            w_load_chain[bus.ch_sel] = 1'b1;
          end
        end else if (bus.shift && w_sel_valid) begin
          w_shift_en[bus.ch_sel] = 1'b1;
          if (!w_sel_chg && r_cnt != CNT_W'(CH_BITS))
            w_cnt_next = r_cnt + 1'b1;
          // Auto-commit fires only on the shift that completes the frame.
          if (bus.auto_commit && !w_sel_chg && r_cnt == CNT_W'(CH_BITS - 1)) begin
            w_state_next  = ST_BLANK;
            w_lat_ch_next = bus.ch_sel;
            w_blank_next  = BC_W'(BLANK_CYC - 1);
          end
        end
      end
      ST_BLANK: begin
        if (r_blank_cnt == '0)
          w_state_next = ST_COMMIT;
        else
          w_blank_next = r_blank_cnt - 1'b1;
      end
      ST_COMMIT: begin
        w_load_state[r_lat_ch] = 1'b1;
        w_state_next           = ST_RESTORE;
      end
      ST_RESTORE: w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_en_next = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!(w_blanking && r_lat_ch == SEL_W'(c)))
        w_en_next[c*EN_BITS +: EN_BITS] = {EN_BITS{bus.en_req[c]}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_prev_sel  <= '0;
      r_lat_ch    <= '0;
      r_cnt       <= '0;
      r_blank_cnt <= '0;
      r_en        <= '0;
    end else begin
      r_state     <= w_state_next;
      r_prev_sel  <= bus.ch_sel;
      r_lat_ch    <= w_lat_ch_next;
      r_cnt       <= w_cnt_next;
      r_blank_cnt <= w_blank_next;
      r_en        <= w_en_next;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pudding_chan_reg #(.CH_BITS(CH_BITS)) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_shift      (w_shift_en[c]),
      .i_load_chain (w_load_chain[c]),
      .i_load_state (w_load_state[c]),
      .i_sdi        (bus.sdi),
      .o_chain      (w_chain[c]),
      .o_state      (w_state[c])
    );
    assign bus.on_code[c*CH_BITS +: CH_BITS] = w_state[c];
  end

  assign bus.sdo        = w_sel_valid ? w_chain[bus.ch_sel][CH_BITS-1] : 1'b0;
  assign bus.frame_done = w_sel_valid && (r_cnt == CNT_W'(CH_BITS));
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.en_out     = r_en;
  assign bus.dbg_state  = r_state;
endmodule
